// File: rtl/ram_dual_port_arbiter.sv
// Round-robin arbiter sharing one dual-read / single-write RAM among four requesters,
// with a primary (read/write) slot, a secondary (read-only) slot and a full-RAM clear sequence.
module ram_dual_port_arbiter #(
  parameter int unsigned UUID       = 0,
  parameter string       NAME       = "",
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 33
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req_valid,
  input  logic [3:0]              req_write,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*WORD_WIDTH-1:0] req_wdata,
  output logic [3:0]              req_ready,
  output logic [3:0]              rsp_valid,
  output logic [4*WORD_WIDTH-1:0] rsp_data,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic                    ram_load0,
  output logic                    ram_load1,
  output logic                    ram_save,
  output logic                    ram_rst,
  output logic [ADDR_WIDTH-1:0]   ram_address0,
  output logic [ADDR_WIDTH-1:0]   ram_address1,
  output logic [WORD_WIDTH-1:0]   ram_in,
  input  logic [WORD_WIDTH-1:0]   ram_out0,
  input  logic [WORD_WIDTH-1:0]   ram_out1
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned PW   = 2;

  if (WORD_WIDTH == 0 || ADDR_WIDTH == 0) begin : g_cfg_check
    $error("%s (uuid %0d): zero-width configuration", NAME, UUID);
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PW-1:0]         rr_ptr;

  logic [ADDR_WIDTH-1:0] addr_of  [NREQ];
  logic [WORD_WIDTH-1:0] wdata_of [NREQ];

  logic                  slot_open;
  logic [PW:0]           pri_hit;
  logic                  pri_found;
  logic [PW-1:0]         pri_idx;
  logic                  pri_wr;
  logic [NREQ-1:0]       sec_cand;
  logic [PW:0]           sec_hit;
  logic                  sec_found;
  logic [PW-1:0]         sec_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_of[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_of[g] = req_wdata[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Lowest set bit of v as {found, index}.
  function automatic logic [PW:0] first_set(input logic [NREQ-1:0] v);
    logic [PW:0] r;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (v[k]) r = {1'b1, PW'(k)};
    end
    return r;
  endfunction

  // Rotate right so that bit sh lands at position 0.
  function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0] v, input logic [PW-1:0] sh);
    logic [2*NREQ-1:0] d;
    d = {v, v} >> sh;
    return d[NREQ-1:0];
  endfunction

  // Slot selection: primary scans from rr_ptr, secondary scans onward from the primary winner.
  always_comb begin
    slot_open = rst && (state == ST_IDLE) && !clear_req;
    pri_hit   = first_set(rotr(req_valid, rr_ptr));
    pri_found = slot_open && pri_hit[PW];
    pri_idx   = PW'(rr_ptr + pri_hit[PW-1:0]);
    pri_wr    = pri_found && req_write[pri_idx];
    for (int j = 0; j < NREQ; j++) begin
      sec_cand[j] = req_valid[j] && !req_write[j] && (PW'(j) != pri_idx)
                    && !(pri_wr && (addr_of[j] == addr_of[pri_idx]));
    end
    sec_hit   = first_set(rotr(sec_cand, PW'(pri_idx + PW'(1))));
    sec_found = pri_found && sec_hit[PW];
    sec_idx   = PW'(pri_idx + PW'(1) + sec_hit[PW-1:0]);
  end

  // State register; clear_busy/ram_rst are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      clear_busy <= 1'b0;
      ram_rst    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_busy <= (state_nxt != ST_IDLE);
      ram_rst    <= (state_nxt == ST_CLEAR);
    end
  end

  // Next-state: a clear request takes one CLEAR cycle plus one DRAIN cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (clear_req) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Grant outputs; everything stays 0 for slots that were not granted.
  always_comb begin
    req_ready    = '0;
    ram_load0    = 1'b0;
    ram_load1    = 1'b0;
    ram_save     = 1'b0;
    ram_address0 = '0;
    ram_address1 = '0;
    ram_in       = '0;
    if (pri_found) begin
      req_ready[pri_idx] = 1'b1;
      ram_address0       = addr_of[pri_idx];
      if (pri_wr) begin
        ram_save = 1'b1;
        ram_in   = wdata_of[pri_idx];
      end else begin
        ram_load0 = 1'b1;
      end
    end
    if (sec_found) begin
      req_ready[sec_idx] = 1'b1;
      ram_load1          = 1'b1;
      ram_address1       = addr_of[sec_idx];
    end
  end

  // Pointer advance and one-cycle completion with captured read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (pri_found) begin
        rr_ptr             <= PW'(pri_idx + PW'(1));
        rsp_valid[pri_idx] <= 1'b1;
        if (!pri_wr) rsp_data[pri_idx*WORD_WIDTH +: WORD_WIDTH] <= ram_out0;
      end
      if (sec_found) begin
        rsp_valid[sec_idx]                          <= 1'b1;
        rsp_data[sec_idx*WORD_WIDTH +: WORD_WIDTH]  <= ram_out1;
      end
    end
  end

endmodule

// File: doc/ram_dual_port_arbiter.md
# ram_dual_port_arbiter

Round-robin arbiter that shares one dual-load RAM (two combinational read ports, one negedge write port sharing address 0) among four requesters. Each cycle it grants up to two accesses: the primary slot (read or write, RAM port 0) and the secondary slot (read only, RAM port 1). It registers read data back to the winners and runs a whole-memory clear sequence on request. It sits between the CPU-side load/store agents and the RAM instance.

## Interface
- UUID, 0, instance id (unused in logic)
- NAME, "", instance name (unused in logic)
- WORD_WIDTH, 16, data word width
- ADDR_WIDTH, 33, RAM address width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req_valid  in  4  per-requester request valid
- req_write  in  4  1=write, 0=read
- req_addr  in  4*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  4*WORD_WIDTH  requester i at [i*WORD_WIDTH +: WORD_WIDTH]
- req_ready  out  4  combinational grant; transfer = valid&ready at posedge
- rsp_valid  out  4  registered one-cycle completion pulse
- rsp_data  out  4*WORD_WIDTH  registered read data per requester
- clear_req  in  1  request full-RAM clear (level, sampled at posedge)
- clear_busy  out  1  high while clear sequence active
- ram_load0 / ram_load1  out  1  RAM load enables
- ram_save  out  1  RAM write enable (port 0 address)
- ram_rst  out  1  RAM clear strobe (active-high)
- ram_address0 / ram_address1  out  ADDR_WIDTH  RAM addresses
- ram_in  out  WORD_WIDTH  RAM write data
- ram_out0 / ram_out1  in  WORD_WIDTH  RAM combinational read data

## Operation
- State: rr_ptr (2 bits), FSM {IDLE, CLEAR, DRAIN}, rsp registers.
- Primary slot (IDLE only): first requester with req_valid, scanning rr_ptr, rr_ptr+1, ... mod 4. It drives ram_address0; read → ram_load0=1; write → ram_save=1, ram_in=its wdata.
- Secondary slot (IDLE only): first requester after the primary winner (same scan order, excluding it) with req_valid & !req_write, and whose address differs from the primary address when the primary is a write (RAW hazard: it waits). It drives ram_address1, ram_load1=1.
- Writes never use the secondary slot; at most one write per cycle.
- Ungranted RAM control lines are 0; ungranted addresses/ram_in are 0.
- rr_ptr update: if the primary slot was granted, rr_ptr <= primary winner + 1 mod 4; else unchanged.
- Completion: at the accept posedge, rsp_valid[i] <= 1 for each winner for one cycle. For read winners, rsp_data[i] <= ram_out0 or ram_out1 as appropriate. Write winners leave rsp_data[i] unchanged.
- FSM:
  - IDLE: clear_req=1 → CLEAR (no grants that cycle; req_ready=0).
  - CLEAR: ram_rst=1, clear_busy=1, no grants → DRAIN.
  - DRAIN: clear_busy=1, no grants (covers the RAM's negedge clear) → IDLE.
  - clear_req held high re-enters CLEAR from IDLE.
- Fairness: a requester holding req_valid is granted within 4 cycles in IDLE.

## Timing
- Grant latency 0 (req_ready combinational from req_valid/req_write/req_addr/rr_ptr/FSM). Response latency 1 cycle after accept.
- Requesters hold valid/write/addr/wdata stable until ready; dropping valid without ready is allowed.
- RAM write commits at the negedge inside the grant cycle.
- Read data is sampled at the posedge that ends the grant cycle. A read granted in the cycle after a write to the same address returns the new data.
- Reset (rst=0, async): rr_ptr=0, FSM=IDLE, rsp_valid=0, rsp_data=0, clear_busy=0, ram_rst=0. All combinational outputs are forced 0 while rst=0.
- Reset mid-clear aborts the sequence; memory contents are then undefined by this block.

## Test plan
- All four reads valid, rr_ptr=0, distinct addresses 1..4 holding 0xA1..0xA4 → cycle 1 grants req0 (port0) and req1 (port1). Cycle 2 grants req2/req3 with rr_ptr=1. rsp_data = 0xA1..0xA4, each one cycle after accept.
- req0 writes 0x1234 @5 while req1 reads @5 → only req0 granted; next cycle req1 is granted on port0 and returns 0x1234.
- Writes on req1 and req2 together → req1 is granted, req2 gets ready=0; next cycle req2 is granted. Never two saves in one cycle.
- req3 continuously valid while req0..2 are also valid → req3 is granted at least once every 4 cycles.
- clear_req pulse with pending reads → 3 cycles with req_ready=0; ram_rst=1 in cycle 2; clear_busy=1 in cycles 2–3. Subsequent reads of previously written addresses return 0.
- Assert rst=0 asynchronously mid-cycle with grants active → rsp_valid, req_ready and RAM controls drop immediately. After release the first grant starts from requester 0.
